// File: rtl/rice_data_memory_responder.sv
// Data-memory responder: word RAM with byte-lane stores and sign/zero-extending loads.
// Optional macro RICE_DATA_MEMORY_MISALIGN_ERROR_EN turns misaligned H/W accesses into error responses.
module rice_data_memory_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_request_valid,
    output logic                     o_request_ready,
    input  logic [1:0]               i_access_type,
    input  logic [2:0]               i_access_mode,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [31:0]              i_write_data,
    output logic                     o_response_valid,
    input  logic                     i_response_ready,
    output logic [31:0]              o_read_data,
    output logic                     o_error
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_READ     = 2'd1;
    localparam logic [1:0] ST_RESPONSE = 2'd2;

    localparam logic [1:0] TYPE_NONE  = 2'd0;
    localparam logic [1:0] TYPE_STORE = 2'd1;
    localparam logic [1:0] TYPE_LOAD  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [31:0]      read_data_reg, read_data_next;
    logic             error_reg, error_next;
    logic [31:0]      mem [DEPTH];
    logic [31:0]      rd_word_reg;
    logic [2:0]       mode_reg;
    logic [1:0]       lane_reg;

    logic             accept;
    logic             is_mem_access;
    logic             mode_reserved;
    logic             req_error;
    logic [1:0]       size_code;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [3:0]       byte_en;
    logic [31:0]      wr_word;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      load_data;

    assign o_request_ready = (state_reg == ST_IDLE) && !i_rst;
    assign accept          = i_request_valid && o_request_ready;
    assign size_code       = i_access_mode[1:0];
    assign idx             = i_address[2 +: IDX_W];
    assign is_mem_access   = (i_access_type == TYPE_STORE) || (i_access_type == TYPE_LOAD);

    always_comb begin
        mode_reserved = 1'b1;
        case (i_access_mode)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: mode_reserved = 1'b0;
            default:                                mode_reserved = 1'b1;
        endcase
    end

`ifdef RICE_DATA_MEMORY_MISALIGN_ERROR_EN
    logic misaligned;
    assign misaligned = ((size_code == 2'd1) && i_address[0]) ||
                        ((size_code == 2'd2) && (i_address[1:0] != 2'b00));
    assign req_error  = (i_access_type == 2'd3) ||
                        (is_mem_access && (mode_reserved || misaligned));
    assign lane       = i_address[1:0];
`else
    // Misaligned accesses silently round down to their natural alignment.
    assign req_error  = (i_access_type == 2'd3) || (is_mem_access && mode_reserved);
    assign lane       = (size_code == 2'd1) ? {i_address[1], 1'b0} :
                        (size_code == 2'd2) ? 2'b00 : i_address[1:0];
`endif

    assign wr_en = accept && (i_access_type == TYPE_STORE) && !req_error;
    assign rd_en = accept && (i_access_type == TYPE_LOAD)  && !req_error;

    // Per-lane enable and data: bytes replicate to every lane, halves to both halves.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            always_comb begin
                case (size_code)
                    2'd0: begin
                        byte_en[gi]         = (lane == LANE);
                        wr_word[gi*8 +: 8]  = i_write_data[7:0];
                    end
                    2'd1: begin
                        byte_en[gi]         = (lane[1] == LANE[1]);
                        wr_word[gi*8 +: 8]  = i_write_data[(gi%2)*8 +: 8];
                    end
                    default: begin
                        byte_en[gi]         = 1'b1;
                        wr_word[gi*8 +: 8]  = i_write_data[gi*8 +: 8];
                    end
                endcase
            end
        end
    endgenerate

    // RAM and load-capture registers carry no reset so the array maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][i*8 +: 8] <= wr_word[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_word_reg <= mem[idx];
            mode_reg    <= i_access_mode;
            lane_reg    <= lane;
        end
    end

    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte  = rd_word_reg[{lane_reg, 3'b000} +: 8];
        sel_half  = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
        load_data = rd_word_reg;
        case (mode_reg[1:0])
            2'd0:    load_data = mode_reg[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'd1:    load_data = mode_reg[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: load_data = rd_word_reg;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        read_data_next = read_data_reg;
        error_next     = error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_error) begin
                        state_next     = ST_RESPONSE;
                        error_next     = 1'b1;
                        read_data_next = 32'd0;
                    end else if (i_access_type == TYPE_LOAD) begin
                        state_next     = ST_READ;
                    end else begin
                        state_next     = ST_RESPONSE;
                        error_next     = 1'b0;
                        read_data_next = 32'd0;
                    end
                end
            end
            ST_READ: begin
                state_next     = ST_RESPONSE;
                read_data_next = load_data;
                error_next     = 1'b0;
            end
            ST_RESPONSE: begin
                if (i_response_ready) begin
                    state_next     = ST_IDLE;
                    read_data_next = 32'd0;
                    error_next     = 1'b0;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                read_data_next = 32'd0;
                error_next     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            read_data_reg <= 32'd0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            read_data_reg <= read_data_next;
            error_reg     <= error_next;
        end
    end

    assign o_response_valid = (state_reg == ST_RESPONSE);
    assign o_read_data      = read_data_reg;
    assign o_error          = error_reg;

    generate
        if (ADDRESS_WIDTH > IDX_W + 2) begin : g_unused_addr
            logic unused_address_bits;
            assign unused_address_bits = ^i_address[ADDRESS_WIDTH-1:IDX_W+2];
        end
    endgenerate

    logic unused_type_none;
    assign unused_type_none = (TYPE_NONE == 2'd0);
endmodule

// File: tb/tb_rice_data_memory_responder.sv
// Bench for rice_data_memory_responder: directed vector table, hand-written corner sequences,
// and random traffic checked against a byte-array memory model.
module tb_rice_data_memory_responder;
    localparam int DEPTH = 1024;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_request_valid;
    logic        o_request_ready;
    logic [1:0]  i_access_type;
    logic [2:0]  i_access_mode;
    logic [31:0] i_address;
    logic [31:0] i_write_data;
    logic        o_response_valid;
    logic        i_response_ready;
    logic [31:0] o_read_data;
    logic        o_error;

    rice_data_memory_responder #(.ADDRESS_WIDTH(32), .DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_request_valid  (i_request_valid),
        .o_request_ready  (o_request_ready),
        .i_access_type    (i_access_type),
        .i_access_mode    (i_access_mode),
        .i_address        (i_address),
        .i_write_data     (i_write_data),
        .o_response_valid (o_response_valid),
        .i_response_ready (i_response_ready),
        .o_read_data      (o_read_data),
        .o_error          (o_error)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [DEPTH*4];

    typedef struct {
        logic [1:0]  t;
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size 1/2/4 bytes from mode, plain arithmetic.
    task automatic model_access(input logic [1:0] t, input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] d, output logic e);
        int size;
        int base;
        logic [31:0] val;
        logic [31:0] mask;
        d = 32'd0;
        e = 1'b0;
        if (t == 2'd3) begin e = 1'b1; return; end
        if (t == 2'd0) return;
        if (m == 3'd3 || m == 3'd6 || m == 3'd7) begin e = 1'b1; return; end
        size = 1 << m[1:0];
`ifdef RICE_DATA_MEMORY_MISALIGN_ERROR_EN
        if ((a % size) != 0) begin e = 1'b1; return; end
`endif
        base = int'((a - (a % size)) % (DEPTH*4));
        if (t == 2'd1) begin
            for (int k = 0; k < size; k++) model_mem[base+k] = 8'((wd >> (8*k)) & 32'hFF);
        end else begin
            val = 32'd0;
            for (int k = 0; k < size; k++) val = val | (32'(model_mem[base+k]) << (8*k));
            if (size < 4) begin
                mask = (32'd1 << (8*size)) - 32'd1;
                if (!m[2] && ((val >> (8*size-1)) & 32'd1) == 32'd1) val = val | ~mask;
            end
            d = val;
        end
    endtask

    task automatic do_req(input string nm, input logic [1:0] t, input logic [2:0] m,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic ee, input int hold);
        int n;
        int lat_exp;
        logic [31:0] d0;
        logic e0;
        n = 0;
        while (!o_request_ready && n < 20) begin @(posedge i_clk); #1; n++; end
        chk({nm, " req_ready"}, 32'(o_request_ready), 32'd1);
        i_access_type    = t;
        i_access_mode    = m;
        i_address        = a;
        i_write_data     = wd;
        i_request_valid  = 1'b1;
        i_response_ready = 1'b0;
        @(posedge i_clk); #1;
        i_request_valid  = 1'b0;
        i_access_type    = 2'($urandom);
        i_access_mode    = 3'($urandom);
        i_address        = $urandom;
        i_write_data     = $urandom;
        n = 1;
        while (!o_response_valid && n < 8) begin @(posedge i_clk); #1; n++; end
        lat_exp = (t == 2'd2 && !ee) ? 2 : 1;
        chk({nm, " latency"}, 32'(n), 32'(lat_exp));
        chk({nm, " data"}, o_read_data, ed);
        chk({nm, " error"}, 32'(o_error), 32'(ee));
        $display("txn %s: type=%0d mode=%0d addr=0x%08h wdata=0x%08h -> data=0x%08h err=%0d lat=%0d",
                 nm, t, m, a, wd, o_read_data, o_error, n);
        d0 = o_read_data;
        e0 = o_error;
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk); #1;
            chk({nm, " hold valid"}, 32'(o_response_valid), 32'd1);
            chk({nm, " hold data"}, o_read_data, d0);
            chk({nm, " hold error"}, 32'(o_error), 32'(e0));
            chk({nm, " hold req_ready"}, 32'(o_request_ready), 32'd0);
        end
        i_response_ready = 1'b1;
        @(posedge i_clk); #1;
        i_response_ready = 1'b0;
        chk({nm, " post valid"}, 32'(o_response_valid), 32'd0);
        chk({nm, " post data"}, o_read_data, 32'd0);
        chk({nm, " post req_ready"}, 32'(o_request_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] md;
        logic        me;
        logic [1:0]  rt;
        logic [2:0]  rm;
        logic [31:0] ra;
        logic [31:0] rw;
        int sel;
        int n;

        for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'd0;

        vecs[0]  = '{2'd1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{2'd2, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{2'd1, 3'b010, 32'h20, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{2'd1, 3'b000, 32'h21, 32'h80,       32'h0,        1'b0};
        vecs[4]  = '{2'd2, 3'b000, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{2'd2, 3'b100, 32'h21, 32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{2'd2, 3'b010, 32'h20, 32'h0,        32'h00008000, 1'b0};
        vecs[7]  = '{2'd1, 3'b010, 32'h30, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{2'd1, 3'b001, 32'h32, 32'h8001,     32'h0,        1'b0};
        vecs[9]  = '{2'd2, 3'b001, 32'h32, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[10] = '{2'd2, 3'b101, 32'h32, 32'h0,        32'h00008001, 1'b0};
        vecs[11] = '{2'd2, 3'b001, 32'h30, 32'h0,        32'h00000000, 1'b0};
        vecs[12] = '{2'd1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[13] = '{2'd1, 3'b011, 32'h40, 32'h12345678, 32'h0,        1'b1};
        vecs[14] = '{2'd2, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[16] = '{2'd0, 3'b010, 32'h40, 32'h0,        32'h0,        1'b0};
        vecs[17] = '{2'd3, 3'b010, 32'h40, 32'h0,        32'h0,        1'b1};
        vecs[18] = '{2'd2, 3'b111, 32'h40, 32'h0,        32'h0,        1'b1};
`ifdef RICE_DATA_MEMORY_MISALIGN_ERROR_EN
        vecs[15] = '{2'd2, 3'b010, 32'h42, 32'h0,        32'h0,        1'b1};
        vecs[19] = '{2'd1, 3'b001, 32'h33, 32'hABCD,     32'h0,        1'b1};
        vecs[20] = '{2'd2, 3'b010, 32'h30, 32'h0,        32'h80010000, 1'b0};
`else
        vecs[15] = '{2'd2, 3'b010, 32'h42, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[19] = '{2'd1, 3'b001, 32'h33, 32'hABCD,     32'h0,        1'b0};
        vecs[20] = '{2'd2, 3'b010, 32'h30, 32'h0,        32'hABCD0000, 1'b0};
`endif

        i_rst            = 1'b1;
        i_request_valid  = 1'b0;
        i_access_type    = 2'd0;
        i_access_mode    = 3'd0;
        i_address        = 32'd0;
        i_write_data     = 32'd0;
        i_response_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset req_ready_in_reset", 32'(o_request_ready), 32'd0);
        chk("reset valid", 32'(o_response_valid), 32'd0);
        chk("reset data", o_read_data, 32'd0);
        chk("reset error", 32'(o_error), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("reset req_ready_after", 32'(o_request_ready), 32'd1);

        for (int i = 0; i < 21; i++) begin
            model_access(vecs[i].t, vecs[i].m, vecs[i].a, vecs[i].wd, md, me);
            do_req($sformatf("vec%0d", i), vecs[i].t, vecs[i].m, vecs[i].a, vecs[i].wd,
                   vecs[i].ed, vecs[i].ee, 0);
        end

        // Backpressure: hold the load response for five cycles.
        model_access(2'd2, 3'b010, 32'h10, 32'h0, md, me);
        do_req("backpressure", 2'd2, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

        // Reset while the load sits in READ: the response must vanish.
        i_access_type   = 2'd2;
        i_access_mode   = 3'b010;
        i_address       = 32'h10;
        i_request_valid = 1'b1;
        @(posedge i_clk); #1;
        i_request_valid = 1'b0;
        chk("rst_in_read req_ready", 32'(o_request_ready), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_in_read valid", 32'(o_response_valid), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_in_read req_ready_after", 32'(o_request_ready), 32'd1);
        n = 0;
        repeat (3) begin
            @(posedge i_clk); #1;
            if (o_response_valid) n++;
        end
        chk("rst_in_read stale_responses", 32'(n), 32'd0);
        $display("txn rst_in_read: stale responses seen=%0d", n);
        do_req("after_rst", 2'd2, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Initialise the random region, then random traffic against the model.
        for (int w = 0; w < 16; w++) begin
            rw = $urandom;
            model_access(2'd1, 3'b010, 32'h100 + 32'(w*4), rw, md, me);
            do_req($sformatf("init%0d", w), 2'd1, 3'b010, 32'h100 + 32'(w*4), rw, md, me, 0);
        end
        for (int r = 0; r < 150; r++) begin
            sel = int'($urandom_range(0, 9));
            rt  = (sel == 0) ? 2'd0 : (sel <= 4) ? 2'd1 : (sel <= 8) ? 2'd2 : 2'd3;
            rm  = 3'($urandom_range(0, 7));
            ra  = 32'h100 + 32'($urandom_range(0, 63));
            rw  = $urandom;
            model_access(rt, rm, ra, rw, md, me);
            do_req($sformatf("rand%0d", r), rt, rm, ra, rw, md, me, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rice_data_memory_responder.md
Name: rice_data_memory_responder

Overview:
Responder end of the core's data-memory access interface: accepts load/store requests tagged with the core's memory-access type and mode (funct3 encoding) and returns a response. Backed by an internal word-organised RAM with byte-lane writes. Loads return byte/halfword data extracted and sign/zero-extended per mode. Sits beside the core as on-chip data RAM and serves as the bench memory model.

Parameters:
ADDRESS_WIDTH, 32, request address width in bits.
DEPTH, 1024, RAM depth in 32-bit words (power of 2, >=2); index = i_address[2+:$clog2(DEPTH)], upper bits ignored.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_request_valid  input  1  request present
o_request_ready  output  1  responder can accept a request
i_access_type  input  2  NONE=0, STORE=1, LOAD=2, 3=reserved
i_access_mode  input  3  B=000, H=001, W=010, BU=100, HU=101, others reserved
i_address  input  ADDRESS_WIDTH  byte address
i_write_data  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
o_response_valid  output  1  response present
i_response_ready  input  1  requester takes response
o_read_data  output  32  load result, extended to 32 bits; 0 for store/NONE/error
o_error  output  1  request rejected (reserved type/mode, or misaligned when feature enabled)

Behaviour:
- One clock i_clk; reset synchronous, active-high on i_rst.
- FSM states: IDLE, READ, RESPONSE. Reset -> IDLE; o_response_valid=0, o_read_data=0, o_error=0. RAM contents not reset.
- o_request_ready = (state==IDLE) && !i_rst; low in READ and RESPONSE (one outstanding request).
- Accept = i_request_valid && o_request_ready. Request fields sampled only at accept; ignored otherwise.
- Error check at accept: type 3, or reserved mode on LOAD/STORE -> no RAM effect, IDLE->RESPONSE, o_error=1, o_read_data=0.
- NONE: IDLE->RESPONSE, o_error=0, o_read_data=0.
- STORE: byte-lane write at accept edge. B: lane addr[1:0] <= wdata[7:0]. H: lanes {addr[1],0},{addr[1],1} <= wdata[15:0]. W: all lanes <= wdata. IDLE->RESPONSE; response valid cycle after accept.
- LOAD: IDLE->READ (registered RAM read of indexed word) ->RESPONSE; response valid 2 cycles after accept. B/BU select byte lane addr[1:0]; H/HU select half addr[1]; W whole word. B/H sign-extend, BU/HU zero-extend.
- RESPONSE: o_response_valid=1; o_read_data/o_error held stable until i_response_ready. On handshake -> IDLE; outputs return to 0 the following cycle. No request accepted in the handshake cycle (ready asserts the cycle after).
- Peak throughput: 1 store / 2 cycles, 1 load / 3 cycles.
- Store followed by load to same word returns updated data (write completes before read issues).
- Reset mid-operation: pending load/response dropped, FSM -> IDLE; a store committed at an earlier edge persists.
- Misalignment (H/HU with addr[0]=1, W with addr[1:0]!=0): handled per optional feature.

Optional Feature:
RICE_DATA_MEMORY_MISALIGN_ERROR_EN
- Defined: misaligned LOAD/STORE -> error response (o_error=1, o_read_data=0), no RAM write, no READ state.
- Undefined: misaligned low address bits forced to alignment (H: addr[0]=0; W: addr[1:0]=0); access proceeds normally, o_error=0.

Test Plan:
- Reset, then STORE W addr 0x10 data 0xDEADBEEF, response_ready=1 -> response 1 cycle after accept, o_read_data=0, o_error=0; LOAD W 0x10 -> 0xDEADBEEF 2 cycles after accept.
- STORE B 0x21 data 0x80 over word 0x00000000; LOAD B 0x21 -> 0xFFFFFF80; LOAD BU 0x21 -> 0x00000080; LOAD W 0x20 -> 0x00008000.
- STORE H 0x32 data 0x8001; LOAD H 0x32 -> 0xFFFF8001; LOAD HU 0x32 -> 0x00008001; LOAD H 0x30 -> 0x00000000.
- Backpressure: LOAD with response_ready=0 for 5 cycles -> valid/data stable, request_ready=0 throughout; new request accepted cycle after handshake.
- Reserved mode 3'b011 STORE to 0x40 data 0x12345678 -> o_error=1; LOAD W 0x40 shows old contents. LOAD W 0x42: with _EN o_error=1; without, returns word at 0x40.
- i_rst asserted in READ state -> next cycle o_response_valid=0, o_request_ready=1 after release; no stale response appears.
